// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, word type, key-schedule FSM states, forward S-box and Rcon.
package aes_pkg;

   localparam int unsigned AES_NR    = 10;
   localparam int unsigned AES_KEY_W = 128;

   typedef logic [31:0] aes_word_t;

   typedef enum logic {
      StIdle,
      StRun
   } aes_state_e;

   // Byte x of the forward S-box lives at bits [(255-x)*8 +: 8].
   localparam logic [2047:0] AES_SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] aes_rcon(input logic [3:0] round);
      logic [7:0] rc;
      case (round)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);

   assign dout = AES_SBOX_TABLE[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Inverse AES-128 key schedule: loads round key NR and streams keys NR..0 on valid/ready.
module aes_inv_key_sched
   import aes_pkg::*;
#(
   parameter int unsigned NR    = AES_NR,
   parameter int unsigned KEY_W = AES_KEY_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [KEY_W-1:0] last_key,
   output logic             busy,
   output logic             key_valid,
   input  logic             key_ready,
   output logic [KEY_W-1:0] round_key,
   output logic [3:0]       round_idx,
   output logic             done
);

   aes_state_e       state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [3:0]       idx_q, idx_d;
   logic             done_q, done_d;

   aes_word_t        wa, wb, wc, wd;
   aes_word_t        prev0, prev1, prev2, prev3;
   aes_word_t        rot_word, sub_word;
   logic [KEY_W-1:0] step_key;

   // One inverse expansion step, straight from key_q; no pipelining in the S-box path.
   assign {wa, wb, wc, wd} = key_q;
   assign prev3    = wd ^ wc;
   assign prev2    = wc ^ wb;
   assign prev1    = wb ^ wa;
   assign rot_word = {prev3[23:0], prev3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .din  (rot_word[8*i +: 8]),
         .dout (sub_word[8*i +: 8])
      );
   end

   assign prev0    = wa ^ sub_word ^ {aes_rcon(idx_q), 24'h0};
   assign step_key = {prev0, prev1, prev2, prev3};

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               key_d   = last_key;
               idx_d   = 4'(NR);
               state_d = StRun;
            end
         end
         StRun: begin
            if (key_ready) begin
               if (idx_q != 4'd0) begin
                  key_d = step_key;
                  idx_d = idx_q - 4'd1;
               end else begin
                  key_d   = '0;
                  idx_d   = 4'd0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         key_q   <= '0;
         idx_q   <= 4'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q == StRun);
   assign key_valid = (state_q == StRun);
   assign round_key = key_q;
   assign round_idx = idx_q;
   assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for the inverse AES-128 key schedule using the FIPS-197 A.1 key.
module tb_aes_inv_key_sched;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] last_key;
   logic         busy;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [127:0] exp_keys [0:10];

   aes_inv_key_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .last_key  (last_key),
      .busy      (busy),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .round_key (round_key),
      .round_idx (round_idx),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_start(input logic [127:0] key);
      start    = 1'b1;
      last_key = key;
      tick();
      start    = 1'b0;
   endtask

   // mode 0: ready=1; 1: 5-cycle stall at round 9; 2: random ready; 3: start pulse at round 5.
   // Returns in the cycle right after the round-0 accept.
   task automatic run_seq(input int mode);
      int beat  = 0;
      int cyc   = 0;
      int stall = 0;
      int dones = 0;
      while (beat < 11 && cyc < 300) begin
         case (mode)
            1:       key_ready = !(round_idx == 4'd9 && stall < 5);
            2:       key_ready = 1'($urandom_range(0, 1));
            default: key_ready = 1'b1;
         endcase
         start = (mode == 3 && key_valid && round_idx == 4'd5);
         if (mode == 3) last_key = '0;
         if (mode == 1 && key_valid && !key_ready) begin
            check("stall_key", round_key, exp_keys[9]);
            check("stall_idx", 128'(round_idx), 128'd9);
            stall++;
         end
         if (done) dones++;
         if (key_valid && key_ready) begin
            check($sformatf("key_r%0d", 10 - beat), round_key, exp_keys[10 - beat]);
            check($sformatf("idx_r%0d", 10 - beat), 128'(round_idx), 128'(10 - beat));
            beat++;
         end
         tick();
         cyc++;
      end
      start     = 1'b0;
      key_ready = 1'b0;
      if (beat < 11) check("seq_timeout", 128'(beat), 128'd11);
      if (mode == 1) check("stall_count", 128'(stall), 128'd5);
      check("early_done", 128'(dones), 128'd0);
      check("done_pulse", 128'(done), 128'd1);
      check("busy_low", 128'(busy), 128'd0);
      check("valid_low", 128'(key_valid), 128'd0);
      check("key_cleared", round_key, 128'd0);
   endtask

   initial begin
      exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      rst_n     = 1'b1;
      start     = 1'b0;
      last_key  = '0;
      key_ready = 1'b0;
      #2 rst_n = 1'b0;
      tick();
      tick();
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_valid", 128'(key_valid), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      check("rst_idx", 128'(round_idx), 128'd0);
      check("rst_key", round_key, 128'd0);
      rst_n = 1'b1;
      tick();

      // Plain run, one key per cycle.
      issue_start(exp_keys[10]);
      check("lat_valid", 128'(key_valid), 128'd1);
      check("lat_busy", 128'(busy), 128'd1);
      run_seq(0);
      tick();
      check("done_one_cycle", 128'(done), 128'd0);

      // Backpressure at round 9.
      issue_start(exp_keys[10]);
      run_seq(1);
      tick();

      // Random ready.
      issue_start(exp_keys[10]);
      run_seq(2);
      tick();
      check("rand_done_once", 128'(done), 128'd0);

      // Start while busy is ignored.
      issue_start(exp_keys[10]);
      run_seq(3);
      tick();
      check("no_restart", 128'(key_valid), 128'd0);

      // Asynchronous reset mid-sequence at round 3.
      issue_start(exp_keys[10]);
      key_ready = 1'b1;
      for (int i = 0; i < 20 && round_idx != 4'd3; i++) tick();
      check("reach_r3", 128'(round_idx), 128'd3);
      rst_n = 1'b0;
      #1;
      check("arst_valid", 128'(key_valid), 128'd0);
      check("arst_busy", 128'(busy), 128'd0);
      check("arst_key", round_key, 128'd0);
      tick();
      rst_n     = 1'b1;
      key_ready = 1'b0;
      check("arst_no_done", 128'(done), 128'd0);
      tick();
      check("arst_no_done2", 128'(done), 128'd0);
      issue_start(exp_keys[10]);
      run_seq(0);

      // Back-to-back start in the done cycle, all-zero key.
      issue_start(128'd0);
      check("b2b_valid", 128'(key_valid), 128'd1);
      check("b2b_key0", round_key, 128'd0);
      check("b2b_idx0", 128'(round_idx), 128'd10);
      key_ready = 1'b1;
      tick();
      check("b2b_key1", round_key, 128'h55636363_00000000_00000000_00000000);
      check("b2b_idx1", 128'(round_idx), 128'd9);
      for (int i = 0; i < 20 && key_valid; i++) tick();
      check("b2b_drained", 128'(key_valid), 128'd0);
      key_ready = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Sequential inverse AES-128 key schedule for on-the-fly decryption keys.
- Accepts the last round key (round NR) and walks backward one round per accepted beat.
- Emits round keys NR, NR-1, ... 0 on a valid/ready stream.
- Inverse of the forward key-expansion word step. Sits between the key-load logic and the decryption datapath's AddRoundKey stage.

Parameters:
- NR, 10, number of AES rounds (AES-128 only; other values unsupported).
- KEY_W, 128, round-key width in bits (fixed to 128).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load request; accepted only when busy=0.
- last_key  input  128  round-NR key {w[4NR], w[4NR+1], w[4NR+2], w[4NR+3]}, MSB word first.
- busy  output  1  high from the cycle after an accepted start until the round-0 key is accepted.
- key_valid  output  1  round_key is valid.
- key_ready  input  1  consumer accepts round_key.
- round_key  output  128  current round key, same word order as last_key.
- round_idx  output  4  round number of round_key (NR down to 0).
- done  output  1  one-cycle pulse after the round-0 key is accepted.

Behaviour:
- Reset is asynchronous and active-low on rst_n, single clock clk. While rst_n=0:
  - busy=0, key_valid=0, done=0, round_idx=0.
  - round_key=0, state=IDLE.
- States:
  - IDLE:
    - start=1 -> key_reg<=last_key, round_idx<=NR, key_valid<=1, busy<=1 -> RUN.
    - Latency: first key valid 1 cycle after start.
  - RUN:
    - key_valid=1 continuously. round_key and round_idx stay stable while key_ready=0.
    - On key_valid&key_ready with round_idx>0: key_reg<=inv_step(key_reg, rcon[round_idx]), round_idx<=round_idx-1. Next key is valid the following cycle (1 key/cycle throughput at key_ready=1).
    - On key_valid&key_ready with round_idx=0: key_valid<=0, busy<=0, done<=1 for one cycle, round_key<=0, round_idx<=0 -> IDLE.
- inv_step for input words {a,b,c,d} = {w[i],w[i+1],w[i+2],w[i+3]}:
  - prev3 = d^c, prev2 = c^b, prev1 = b^a.
  - prev0 = a ^ SubWord(RotWord(prev3)) ^ {rcon,24'h0}.
  - Output {prev0,prev1,prev2,prev3}.
  - RotWord is a left byte rotate: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
- rcon[r] for r=1..10: 01,02,04,08,10,20,40,80,1b,36. rcon[0] is unused.
- start while busy=1 is ignored, with no effect on the sequence in flight.
- start in the same cycle as the final accept: the start is ignored because busy is still 1. The producer re-issues it after done.
- key_ready asserted while key_valid=0 has no effect.
- Reset mid-sequence aborts immediately to the reset values. No done pulse is generated.
- The S-box path is combinational from key_reg. No registered S-box.

Decomposition:
- Shared package aes_pkg:
  - AES_NR=10, AES_KEY_W=128.
  - Rcon lookup function.
  - State enum {IDLE, RUN}.
  - Word type (32-bit).
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4 times for SubWord. Reused by the forward key-expansion and encryption paths.

Test Plan:
- FIPS-197 A.1 key, key_ready=1 throughout. start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> 11 beats:
  - beat 0: round_idx=10, last_key echoed.
  - beat 1: round_idx=9, ac7766f319fadc2128d12941575c006e.
  - beat 10: round_idx=0, 2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses 1 cycle after beat 10; busy falls in the same cycle.
- Backpressure: same key, key_ready=0 for 5 cycles at round_idx=9 -> round_key stays ac7766f3... and round_idx=9 for all 5 cycles; the sequence then resumes correctly to round 0.
- Random key_ready toggling (50%) -> the 11 accepted keys equal the forward-expanded schedule of 2b7e1516... reversed; exactly one done pulse.
- start pulsed at round_idx=5 -> ignored; the sequence completes with the original values and no restart.
- rst_n low for 1 cycle at round_idx=3 -> key_valid=0, busy=0, round_key=0 asynchronously; no done. A new start afterwards runs the full 11-beat sequence.
- Back-to-back: start asserted the cycle after done with last_key=0 -> beat 0 round_key=0, round_idx=10. Beat 1 matches the software model inv_step(0, 0x36).
